// File: rtl/div_pkg.sv
// Shared definitions for the divider core and the requesting execute-stage
// divide unit.
//   div_state_t          : core FSM states
//   DIV_WIDTH            : default operand width
//   DIV_CNT_W            : iteration counter width for DIV_WIDTH
//   DOUT_Q_* / DOUT_R_*  : quotient/remainder slices of m_axis_dout_tdata
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  localparam int unsigned DOUT_Q_MSB = 2 * DIV_WIDTH - 1;
  localparam int unsigned DOUT_Q_LSB = DIV_WIDTH;
  localparam int unsigned DOUT_R_MSB = DIV_WIDTH - 1;
  localparam int unsigned DOUT_R_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step (combinational).
//   rem      : current partial remainder (always < divisor when divisor != 0)
//   divisor  : divisor magnitude
//   dvd_bit  : next dividend bit, MSB first
//   rem_next : updated partial remainder
//   q_bit    : quotient bit produced by this step
module div_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // One extra bit so divisors with the MSB set (e.g. |most-negative|)
  // still compare correctly against the shifted remainder.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, dvd_bit};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/axis_div_core.sv
// Iterative divider behind the execute-stage divide functional unit.
// Accepts a dividend/divisor pair when both tvalids are high in IDLE, runs
// WIDTH restoring steps on magnitudes, sign-corrects, and emits a one-cycle
// result beat WIDTH+1 cycles after the accept edge. No backpressure.
//   clk, rst                : clock, synchronous active-high reset
//   s_axis_dividend_tvalid/tdata : dividend operand
//   s_axis_divisor_tvalid/tdata  : divisor operand
//   m_axis_dout_tvalid      : one-cycle result pulse
//   m_axis_dout_tdata       : {quotient, remainder}, held until next result
module axis_div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             accept;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .divisor  (dsr),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (SIGNED) begin
      sa = s_axis_dividend_tdata[WIDTH-1];
      sb = s_axis_divisor_tdata[WIDTH-1];
    end
    a_mag  = sa ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    b_mag  = sb ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
    accept = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    // Divide by zero: the step chain already leaves |dividend| in rem, so
    // re-applying the dividend sign restores the original dividend; only
    // the quotient needs forcing. Most-negative / -1 wraps to most-negative
    // naturally through the negate.
    q_fix = q_neg ? -dvd_q : dvd_q;
    if (dz) q_fix = '1;
    r_fix = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      dvd_q              <= '0;
      dsr                <= '0;
      rem                <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      dz                 <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_q <= a_mag;
            dsr   <= b_mag;
            rem   <= '0;
            q_neg <= sa ^ sb;
            r_neg <= sa;
            dz    <= (s_axis_divisor_tdata == '0);
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          rem   <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          m_axis_dout_tdata  <= {q_fix, r_fix};
          m_axis_dout_tvalid <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_div_core.sv
module tb_axis_div_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        dvd_valid;
  logic [31:0] dvd_data;
  logic        dsr_valid;
  logic [31:0] dsr_data;
  logic        dout_valid;
  logic [63:0] dout_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[14];

  axis_div_core #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dsr_valid),
    .s_axis_divisor_tdata   (dsr_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tdata      (dout_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; presents both operands for exactly one edge (E0)
  // and returns at the negedge following E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dvd_valid = 1'b1; dvd_data = a;
    dsr_valid = 1'b1; dsr_data = b;
    @(posedge clk);
    @(negedge clk);
    dvd_valid = 1'b0; dsr_valid = 1'b0;
    dvd_data = '0; dsr_data = '0;
  endtask

  // Called at the negedge after E0; k counts edges since E0. Returns at the
  // negedge after E34, so an immediate issue() accepts at E35.
  task automatic await_result(input string name, input logic [63:0] exp);
    int lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dout_valid) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " data"}, dout_data, exp);
    @(negedge clk);
    check({name, " pulse end"}, {63'd0, dout_valid}, 64'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{"100/7",       32'd100,        32'd7,          64'h0000000E_00000002};
    vecs[1]  = '{"-7/2",        32'hFFFFFFF9,   32'd2,          64'hFFFFFFFD_FFFFFFFF};
    vecs[2]  = '{"7/-2",        32'd7,          32'hFFFFFFFE,   64'hFFFFFFFD_00000001};
    vecs[3]  = '{"5/0",         32'd5,          32'd0,          64'hFFFFFFFF_00000005};
    vecs[4]  = '{"minneg/-1",   32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
    vecs[5]  = '{"-100/-7",     32'hFFFFFF9C,   32'hFFFFFFF9,   64'h0000000E_FFFFFFFE};
    vecs[6]  = '{"-5/0",        32'hFFFFFFFB,   32'd0,          64'hFFFFFFFF_FFFFFFFB};
    vecs[7]  = '{"0/5",         32'd0,          32'd5,          64'h00000000_00000000};
    vecs[8]  = '{"3/7",         32'd3,          32'd7,          64'h00000000_00000003};
    vecs[9]  = '{"maxpos/1",    32'h7FFFFFFF,   32'd1,          64'h7FFFFFFF_00000000};
    vecs[10] = '{"minneg/2",    32'h80000000,   32'd2,          64'hC0000000_00000000};
    vecs[11] = '{"minneg/max",  32'h80000000,   32'h7FFFFFFF,   64'hFFFFFFFF_FFFFFFFF};
    vecs[12] = '{"maxpos/min",  32'h7FFFFFFF,   32'h80000000,   64'h00000000_7FFFFFFF};
    vecs[13] = '{"1000000/-3",  32'd1000000,    32'hFFFFFFFD,   64'hFFFAE9EB_00000001};

    rst = 1'b1;
    dvd_valid = 1'b0; dvd_data = '0;
    dsr_valid = 1'b0; dsr_data = '0;
    repeat (3) @(negedge clk);
    check("reset tvalid", {63'd0, dout_valid}, 64'd0);
    check("reset tdata", dout_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each issued back-to-back at E35 of the previous one.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      await_result(vecs[i].name, vecs[i].exp);
    end

    // Dividend alone for 5 edges, then divisor joins.
    repeat (2) @(negedge clk);
    dvd_valid = 1'b1; dvd_data = 32'd100;
    repeat (5) @(negedge clk);
    check("lone dividend idle", {63'd0, dout_valid}, 64'd0);
    issue(32'd100, 32'd7);
    await_result("staggered", 64'h0000000E_00000002);

    // Requester handshake: hold both until the result is seen, drop one
    // cycle later; exactly one pulse must appear.
    repeat (2) @(negedge clk);
    dvd_valid = 1'b1; dvd_data = 32'd9;
    dsr_valid = 1'b1; dsr_data = 32'd3;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dout_valid) begin
        pulses++;
        check("held data", dout_data, 64'h00000003_00000000);
        break;
      end
    end
    @(negedge clk);
    dvd_valid = 1'b0; dsr_valid = 1'b0;
    dvd_data = '0; dsr_data = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dout_valid) pulses++;
    end
    check("held pulse count", 64'(pulses), 64'd1);

    // Reset at cycle 10 of an operation abandons it.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst tvalid", {63'd0, dout_valid}, 64'd0);
    check("midrst tdata", dout_data, 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dout_valid) pulses++;
    end
    check("midrst no result", 64'(pulses), 64'd0);
    issue(32'd9, 32'd3);
    await_result("post-reset 9/3", 64'h00000003_00000000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
